// File: rtl/trace_logger.sv
// Memory side of the data trace buffer.
// Trace mode captures tracer stores into a circular RAM until the post-trigger
// delay expires, then freezes it for system readout. Stream mode turns the
// same RAM into a FIFO that the system fills and the tracer drains.
module trace_logger #(
    parameter int unsigned TRB_WIDTH      = 32,
    parameter int unsigned TRB_DEPTH      = 64,
    parameter int unsigned TRB_DELAY_BITS = 16,
    localparam int unsigned AW            = $clog2(TRB_DEPTH)
) (
    input  logic                      CLK_I,
    input  logic                      RST_NI,
    input  logic                      EN_I,
    input  logic                      MODE_I,
    input  logic [TRB_DELAY_BITS-1:0] TRG_DELAY_I,
    input  logic                      TRG_EVENT_I,
    input  logic [TRB_WIDTH-1:0]      EVENT_POS_I,
    input  logic                      STORE_I,
    input  logic [TRB_WIDTH-1:0]      DATA_I,
    input  logic                      LOAD_I,
    output logic [TRB_WIDTH-1:0]      DATA_O,
    output logic                      LOAD_O,
    output logic                      TRG_EVENT_O,
    output logic [AW-1:0]             TRG_ADDR_O,
    output logic [TRB_WIDTH-1:0]      EVENT_POS_O,
    output logic [AW-1:0]             WR_PTR_O,
    input  logic                      SYS_WE_I,
    input  logic [TRB_WIDTH-1:0]      SYS_WDATA_I,
    input  logic                      SYS_RE_I,
    input  logic [AW-1:0]             SYS_ADDR_I,
    output logic [TRB_WIDTH-1:0]      SYS_RDATA_O,
    output logic                      SYS_RVALID_O,
    output logic                      FULL_O,
    output logic                      EMPTY_O,
    output logic                      OVF_O,
    output logic                      UDF_O
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StPreTrigger,
        StPostTrigger,
        StDone,
        StStream
    } state_e;

    state_e                    state_q;
    logic                      mode_q;     // mode latched when leaving idle
    logic [AW-1:0]             wr_ptr_q;
    logic [AW-1:0]             rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic [TRB_DELAY_BITS-1:0] dly_q;

    logic [TRB_WIDTH-1:0]      mem [TRB_DEPTH];

    logic                      abort;
    logic                      full;
    logic                      empty;
    logic                      ld_ok;
    logic                      mem_we;
    logic [TRB_WIDTH-1:0]      mem_wdata;

    assign full     = (count_q == CW'(TRB_DEPTH));
    assign empty    = (count_q == '0);
    assign FULL_O   = full;
    assign EMPTY_O  = empty;
    assign WR_PTR_O = wr_ptr_q;

    // Select the single RAM write source; an abort suppresses all activity.
    always_comb begin
        abort     = (state_q != StIdle) && (!EN_I || (MODE_I != mode_q));
        ld_ok     = LOAD_I && !empty;
        mem_we    = 1'b0;
        mem_wdata = DATA_I;
        if (!abort) begin
            case (state_q)
                StPreTrigger,
                StPostTrigger: mem_we = STORE_I;
                StStream: begin
                    mem_we    = SYS_WE_I && !full;
                    mem_wdata = SYS_WDATA_I;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    // Trace / FIFO RAM write port; reads happen in the FSM block (read-first).
    always_ff @(posedge CLK_I) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    // Main FSM with all registered outputs.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dly_q        <= '0;
            DATA_O       <= '0;
            LOAD_O       <= 1'b0;
            TRG_EVENT_O  <= 1'b0;
            TRG_ADDR_O   <= '0;
            EVENT_POS_O  <= '0;
            SYS_RDATA_O  <= '0;
            SYS_RVALID_O <= 1'b0;
            OVF_O        <= 1'b0;
            UDF_O        <= 1'b0;
        end else begin
            LOAD_O       <= 1'b0;
            SYS_RVALID_O <= 1'b0;
            if (mem_we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            if (abort) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                        dly_q    <= '0;
                        if (EN_I) begin
                            mode_q      <= MODE_I;
                            OVF_O       <= 1'b0;
                            UDF_O       <= 1'b0;
                            TRG_EVENT_O <= 1'b0;
                            TRG_ADDR_O  <= '0;
                            EVENT_POS_O <= '0;
                            state_q     <= MODE_I ? StStream : StPreTrigger;
                        end
                    end
                    StPreTrigger: begin
                        if (LOAD_I) begin
                            DATA_O <= mem[wr_ptr_q];
                            LOAD_O <= 1'b1;
                        end
                        if (TRG_EVENT_I) begin
                            // A concurrent store is the trigger word itself.
                            TRG_ADDR_O  <= wr_ptr_q;
                            EVENT_POS_O <= EVENT_POS_I;
                            dly_q       <= TRG_DELAY_I;
                            state_q     <= StPostTrigger;
                        end
                    end
                    StPostTrigger: begin
                        if (LOAD_I) begin
                            DATA_O <= mem[wr_ptr_q];
                            LOAD_O <= 1'b1;
                        end
                        if (STORE_I) begin
                            if (dly_q == '0) begin
                                TRG_EVENT_O <= 1'b1;
                                state_q     <= StDone;
                            end else begin
                                dly_q <= dly_q - 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        if (SYS_RE_I) begin
                            SYS_RDATA_O  <= mem[SYS_ADDR_I];
                            SYS_RVALID_O <= 1'b1;
                        end
                    end
                    StStream: begin
                        if (ld_ok) begin
                            DATA_O   <= mem[rd_ptr_q];
                            LOAD_O   <= 1'b1;
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end else if (LOAD_I) begin
                            UDF_O <= 1'b1;
                        end
                        if (SYS_WE_I && full) begin
                            OVF_O <= 1'b1;
                        end
                        case ({mem_we, ld_ok})
                            2'b10:   count_q <= count_q + 1'b1;
                            2'b01:   count_q <= count_q - 1'b1;
                            default: count_q <= count_q;
                        endcase
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
